// File: rtl/pc_gen_unit.sv
// Program-counter generator feeding the instruction fetch stage.
// Offers one PC at a time, advances on commit (sequential or redirect) and halts on a misaligned target.
module pc_gen_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int          CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    input  logic             commit_valid,
    input  logic             redir_valid,
    input  logic [31:0]      redir_pc,
    output logic             misalign_err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        pc_r;
    logic [31:0]        pc_next_s;
    logic               valid_r;
    logic               valid_next_s;
    logic               err_r;
    logic               err_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               commit_take_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    assign commit_take_s = (state_r == ST_WAIT) && commit_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: state_next_s = ST_REQ;
            ST_REQ: begin
                if (out_ready) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (commit_valid) begin
                    if (redir_valid && is_misaligned(redir_pc)) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_REQ;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_BOOT;
        endcase
    end

    // Output/datapath next values; a misaligned redirect still retires but leaves the PC alone
    always_comb begin
        pc_next_s    = pc_r;
        err_next_s   = err_r;
        cnt_next_s   = cnt_r;
        valid_next_s = (state_next_s == ST_REQ);
        if (commit_take_s) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (redir_valid) begin
                if (is_misaligned(redir_pc)) begin
                    err_next_s = 1'b1;
                end else begin
                    pc_next_s = redir_pc;
                end
            end else begin
                pc_next_s = pc_r + 32'd4;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r    <= RESET_VECTOR;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            pc_r    <= pc_next_s;
            valid_r <= valid_next_s;
            err_r   <= err_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign out_valid    = valid_r;
    assign out_pc       = pc_r;
    assign misalign_err = err_r;
    assign instret      = cnt_r;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: inputs driven and outputs sampled on the falling clock edge.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic        commit_valid = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        misalign_err;
    logic [63:0] instret;

    int total = 0;
    int bad   = 0;

    pc_gen_unit #(.RESET_VECTOR(32'h8000_0000), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .commit_valid(commit_valid), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .misalign_err(misalign_err), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b1; commit_valid = 1'b0; redir_valid = 1'b0;
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_pc !== 32'h8000_0000) begin bad++; $display("FAIL reset_pc got=%h want=80000000", out_pc); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", misalign_err); end
        total++; if (instret !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
        rst = 1'b1;
        tick();  // BOOT cycle
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL boot_to_req_valid got=%b want=1", out_valid); end
        total++; if (out_pc !== 32'h8000_0000) begin bad++; $display("FAIL first_pc got=%h want=80000000", out_pc); end
        tick();  // handshake taken
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL after_hs_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_back_pressure();
        rst = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid); end
            total++; if (out_pc !== 32'h8000_0000) begin bad++; $display("FAIL bp_pc cyc=%0d got=%h want=80000000", i, out_pc); end
            tick();
        end
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_still_valid got=%b want=1", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_accept got=%b want=0", out_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h8000_0004; exp_pc[1] = 32'h8000_0008; exp_pc[2] = 32'h8000_000C;
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1'b1;
            tick();
            commit_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL seq_valid i=%0d got=%b want=1", i, out_valid); end
            total++; if (out_pc !== exp_pc[i]) begin bad++; $display("FAIL seq_pc i=%0d got=%h want=%h", i, out_pc, exp_pc[i]); end
            tick();
        end
        total++; if (instret !== 64'd3) begin bad++; $display("FAIL seq_instret got=%0d want=3", instret); end
    endtask

    task automatic test_redirect();
        redir_valid = 1'b1; redir_pc = 32'h8000_0200;
        repeat (2) tick();  // no commit: redirect must be ignored
        total++; if (out_pc !== 32'h8000_000C) begin bad++; $display("FAIL redir_nocommit_pc got=%h want=8000000c", out_pc); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_nocommit_valid got=%b want=0", out_valid); end
        total++; if (instret !== 64'd3) begin bad++; $display("FAIL redir_nocommit_instret got=%0d want=3", instret); end
        redir_pc = 32'h8000_0100; commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0; redir_valid = 1'b0;
        total++; if (out_pc !== 32'h8000_0100) begin bad++; $display("FAIL redir_pc got=%h want=80000100", out_pc); end
        total++; if (instret !== 64'd4) begin bad++; $display("FAIL redir_instret got=%0d want=4", instret); end
        tick();
        // self-loop redirect refetches the same address
        redir_valid = 1'b1; commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0; redir_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0100) begin bad++; $display("FAIL self_loop valid=%b pc=%h want 1/80000100", out_valid, out_pc); end
        tick();
    endtask

    task automatic test_back_to_back();
        commit_valid = 1'b1; out_ready = 1'b0;
        tick();  // commit taken, now REQ at 0x80000104
        redir_valid = 1'b1; redir_pc = 32'h8000_0400;
        repeat (2) tick();  // commits in REQ ignored
        commit_valid = 1'b0; redir_valid = 1'b0;
        total++; if (out_pc !== 32'h8000_0104) begin bad++; $display("FAIL req_ignore_pc got=%h want=80000104", out_pc); end
        total++; if (instret !== 64'd6) begin bad++; $display("FAIL req_ignore_instret got=%0d want=6", instret); end
        out_ready = 1'b1;
        tick();
        commit_valid = 1'b1;
        tick();  // commit at edge N, re-accept at edge N+1
        commit_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0108) begin bad++; $display("FAIL b2b valid=%b pc=%h want 1/80000108", out_valid, out_pc); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b want=0", out_valid); end
    endtask

    task automatic test_misalign();
        commit_valid = 1'b1; redir_valid = 1'b1; redir_pc = 32'h8000_0102;
        tick();
        redir_valid = 1'b0;
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", misalign_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%b want=0", out_valid); end
        total++; if (out_pc !== 32'h8000_0108) begin bad++; $display("FAIL mis_pc got=%h want=80000108", out_pc); end
        total++; if (instret !== 64'd8) begin bad++; $display("FAIL mis_instret got=%0d want=8", instret); end
        repeat (3) tick();  // HALT ignores further commits
        commit_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || misalign_err !== 1'b1 || instret !== 64'd8) begin
            bad++; $display("FAIL halt_hold valid=%b err=%b instret=%0d want 0/1/8", out_valid, misalign_err, instret); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if (misalign_err !== 1'b0 || instret !== 64'd0 || out_pc !== 32'h8000_0000) begin
            bad++; $display("FAIL halt_reset err=%b instret=%0d pc=%h want 0/0/80000000", misalign_err, instret, out_pc); end
    endtask

    task automatic test_wrap_and_reset_in_req();
        out_ready = 1'b1;
        repeat (2) tick();  // BOOT -> REQ -> accepted
        commit_valid = 1'b1; redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
        tick();
        commit_valid = 1'b0; redir_valid = 1'b0;
        total++; if (out_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h want=fffffffc", out_pc); end
        tick();
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_pc !== 32'h0000_0000 || out_valid !== 1'b1) begin bad++; $display("FAIL wrap pc=%h valid=%b want 00000000/1", out_pc, out_valid); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b want=0", misalign_err); end
        tick();
        rst = 1'b0;  // reset mid-handshake
        tick();
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0000) begin bad++; $display("FAIL req_reset valid=%b pc=%h want 0/80000000", out_valid, out_pc); end
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000) begin bad++; $display("FAIL req_reset_restart valid=%b pc=%h want 1/80000000", out_valid, out_pc); end
    endtask

    initial begin
        tick();
        test_reset();
        test_back_pressure();
        test_sequential();
        test_redirect();
        test_back_to_back();
        test_misalign();
        test_wrap_and_reset_in_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
